mem_set_ctrl: RTL and testbench

Board-side editor that drives the data memory's manual-override port (MemSet/MemNum/MemVal) from four push-buttons, so memory words can be inspected and changed from the FPGA board while the MIPS pipeline runs. It sits directly upstream of the data memory in the top level. It debounces the buttons, keeps an edit cursor and value, and holds MemSet until the memory accepts it. The memory gives pipeline stores (MemWrite) priority over MemSet, so this block owns the retry handshake.

---
 rtl/mem_set_ctrl_pkg.sv | 20 ++
 rtl/mem_set_ctrl_btn_debounce.sv | 60 ++++++
 rtl/mem_set_ctrl.sv | 82 ++++++++
 tb/tb_mem_set_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_set_ctrl_pkg.sv
// Shared types and default widths for the board-side memory override editor.
// Default widths are also used by the data memory instance.
package mem_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int NUM_WIDTH_DEF = 2;
  localparam int VAL_WIDTH_DEF = 3;

  // Bit positions of the press vector inside the top.
  localparam int B_DOWN = 0;
  localparam int B_UP   = 1;
  localparam int B_SEL  = 2;
  localparam int B_LOAD = 3;

endpackage

// File: rtl/mem_set_ctrl_btn_debounce.sv
// One push-button: 2-FF synchronizer, optional counter filter, rising-edge press pulse.
// The counter filter exists only when MEM_SET_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

`ifdef MEM_SET_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic sync1_q, sync2_q, prev_q, filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= filt;
    end
  end

  if (DEB_EN) begin : g_deb
    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // Level flips on the DEB_CYCLES-th consecutive disagreeing edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else if (sync2_q != filt_q) begin
        if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          cnt_q  <= '0;
          filt_q <= sync2_q;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
    assign filt = filt_q;
  end else begin : g_nodeb
    assign filt = sync2_q;
  end

  assign press_o = filt & ~prev_q;

endmodule

// File: rtl/mem_set_ctrl.sv
// Push-button editor driving the data memory override port (MemSet/MemNum/MemVal).
// Optional button debounce filter: define MEM_SET_DEBOUNCE_EN.
module mem_set_ctrl
  import mem_set_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int NUM_WIDTH  = NUM_WIDTH_DEF,
  parameter int VAL_WIDTH  = VAL_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 BtnSel,
  input  logic                 BtnUp,
  input  logic                 BtnDown,
  input  logic                 BtnLoad,
  input  logic                 MemWrite,
  output logic                 MemSet,
  output logic [NUM_WIDTH-1:0] MemNum,
  output logic [VAL_WIDTH-1:0] MemVal,
  output logic                 Pending
);

  logic [3:0] raw, press;
  assign raw = {BtnLoad, BtnSel, BtnUp, BtnDown};

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db [3:0] (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (raw),
    .press_o(press)
  );

  state_e               state_q, state_d;
  logic [NUM_WIDTH-1:0] num_q, num_d;
  logic [VAL_WIDTH-1:0] val_q, val_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      val_q   <= val_d;
    end
  end

  // Load > Sel > Up > Down; COMMIT ignores presses and waits for a MemWrite-free edge.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    val_d   = val_q;
    case (state_q)
      ST_IDLE, ST_EDIT: begin
        if (press[B_LOAD]) begin
          state_d = ST_COMMIT;
        end else if (press[B_SEL]) begin
          num_d   = num_q + 1'b1;
          val_d   = '0;
          state_d = ST_IDLE;
        end else if (press[B_UP]) begin
          val_d   = val_q + 1'b1;
          state_d = ST_EDIT;
        end else if (press[B_DOWN]) begin
          val_d   = val_q - 1'b1;
          state_d = ST_EDIT;
        end
      end
      ST_COMMIT: begin
        if (!MemWrite) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign MemSet  = (state_q == ST_COMMIT);
  assign Pending = (state_q == ST_EDIT);
  assign MemNum  = num_q;
  assign MemVal  = val_q;

endmodule

// File: tb/tb_mem_set_ctrl.sv
// Self-checking bench for mem_set_ctrl: directed steps plus randomized presses
// checked against an abstract editor model (cursor, value, edit flag).
module tb_mem_set_ctrl;

  localparam int DEB = 4;
`ifdef MEM_SET_DEBOUNCE_EN
  localparam int LAT = 2 + DEB + 1;
`else
  localparam int LAT = 3;
`endif
  localparam int NW = 2;
  localparam int VW = 3;

  logic clk, rst;
  logic BtnSel, BtnUp, BtnDown, BtnLoad, MemWrite;
  logic MemSet, Pending;
  logic [NW-1:0] MemNum;
  logic [VW-1:0] MemVal;

  mem_set_ctrl #(.DEB_CYCLES(DEB), .NUM_WIDTH(NW), .VAL_WIDTH(VW)) dut (
    .clk(clk), .rst(rst), .BtnSel(BtnSel), .BtnUp(BtnUp), .BtnDown(BtnDown),
    .BtnLoad(BtnLoad), .MemWrite(MemWrite), .MemSet(MemSet), .MemNum(MemNum),
    .MemVal(MemVal), .Pending(Pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: word cursor, edit value, uncommitted-edit flag.
  int m_num = 0;
  int m_val = 0;
  int m_edit = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".num"}, 32'(MemNum), m_num);
    check({tag, ".val"}, 32'(MemVal), m_val);
    check({tag, ".pend"}, 32'(Pending), m_edit);
    check({tag, ".set"}, 32'(MemSet), 0);
  endtask

  task automatic set_btns(input logic [3:0] m);
    {BtnLoad, BtnSel, BtnUp, BtnDown} = m;
  endtask

  // Non-load press; mask {load,sel,up,down}, load bit must be 0.
  task automatic press(input logic [3:0] m, input string tag);
    @(negedge clk);
    set_btns(m);
    repeat (LAT + 2) @(negedge clk);
    set_btns(4'b0);
    repeat (LAT + 2) @(negedge clk);
    if (m[2]) begin
      m_num = (m_num + 1) % (1 << NW); m_val = 0; m_edit = 0;
    end else if (m[1]) begin
      m_val = (m_val + 1) % (1 << VW); m_edit = 1;
    end else if (m[0]) begin
      m_val = (m_val + (1 << VW) - 1) % (1 << VW); m_edit = 1;
    end
    check_outs(tag);
  endtask

  // Load press (plus extra raw bits), MemWrite held k edges while MemSet is up.
  task automatic commit(input int k, input logic [3:0] extra, input bit up_during, input string tag);
    int t;
    int hi;
    @(negedge clk);
    MemWrite = 1'b1;
    set_btns(4'b1000 | extra);
    t = 0;
    while (!MemSet && t < LAT + 10) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".seen"}, 32'(MemSet), 1);
    check({tag, ".fnum"}, 32'(MemNum), m_num);
    check({tag, ".fval"}, 32'(MemVal), m_val);
    check({tag, ".fpend"}, 32'(Pending), 0);
    set_btns(up_during ? 4'b0010 : 4'b0000);
    hi = 1;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (MemSet) hi++;
    end
    check({tag, ".hval"}, 32'(MemVal), m_val);
    MemWrite = 1'b0;
    @(negedge clk);
    if (MemSet) hi++;
    check({tag, ".len"}, hi, k + 1);
    set_btns(4'b0);
    repeat (LAT + 2) @(negedge clk);
    m_edit = 0;
    check_outs(tag);
  endtask

  initial begin
    int kd;
    rst = 1'b1;
    MemWrite = 1'b0;
    set_btns(4'b0);
    repeat (2) @(negedge clk);
    check_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Exact latency of the first Up press; a held button counts once.
    set_btns(4'b0010);
    repeat (LAT - 1) @(posedge clk);
    #1 check("lat.before", 32'(MemVal), 0);
    @(posedge clk);
    #1 check("lat.at", 32'(MemVal), 1);
    check("lat.pend", 32'(Pending), 1);
    repeat (10) @(negedge clk);
    set_btns(4'b0);
    repeat (LAT + 2) @(negedge clk);
    m_val = 1; m_edit = 1;
    check_outs("hold_once");

`ifdef MEM_SET_DEBOUNCE_EN
    set_btns(4'b0010);
    repeat (3) @(negedge clk);
    set_btns(4'b0);
    repeat (LAT + 4) @(negedge clk);
    check_outs("glitch");
`endif

    press(4'b0100, "sel1");
    press(4'b0100, "sel2");
    press(4'b0100, "sel3");
    press(4'b0100, "sel0");
    press(4'b0001, "down_wrap");
    press(4'b0100, "sel_discard");
    while (m_num != 2) press(4'b0100, "sel_to2");
    repeat (5) press(4'b0010, "up_to5");
    commit(0, 4'b0000, 1'b0, "commit_free");

    kd = (LAT + 2 > 6) ? LAT + 2 : 6;
    commit(kd, 4'b0000, 1'b1, "commit_hold");
    commit(0, 4'b0010, 1'b0, "load_up_same");

    // Asynchronous reset in the middle of a held commit.
    @(negedge clk);
    MemWrite = 1'b1;
    set_btns(4'b1000);
    repeat (LAT + 2) @(negedge clk);
    check("rstc.set", 32'(MemSet), 1);
    #2 rst = 1'b1;
    #1;
    check("rstc.set0", 32'(MemSet), 0);
    check("rstc.num0", 32'(MemNum), 0);
    check("rstc.val0", 32'(MemVal), 0);
    check("rstc.pend0", 32'(Pending), 0);
    set_btns(4'b0);
    MemWrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_num = 0; m_val = 0; m_edit = 0;
    repeat (LAT + 2) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 4)
        commit($urandom_range(0, 4), 4'b0000, 1'b0, "rnd_commit");
      else
        press(4'($urandom_range(1, 7)), "rnd_press");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
